instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch-side initiator for the synchronous-read instruction memory. Drives the word address and captures the instruction returned one cycle later.
- Holds a program counter and buffers responses in a 2-entry queue. Presents {pc, instruction} to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute.

Parameters:
- ADDR_BITS, 10: instruction memory word-address width.
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- im_address  out  ADDR_BITS  word address to instruction memory; the memory latches it every posedge.
- im_instruction  in  `DATA_BITS  memory read data; corresponds to the im_address of the previous cycle.
- redirect_valid  in  1  redirect fetch this cycle.
- redirect_pc  in  `DATA_BITS  redirect target byte address.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts when out_valid is also high.
- out_instruction  out  `DATA_BITS  instruction word.
- out_pc  out  `DATA_BITS  byte address of out_instruction.

Behaviour:
- **Address formation.** im_address = fetch_pc[ADDR_BITS+1:2].
  - fetch_pc = redirect_valid ? {redirect_pc[31:2],2'b00} : req_pc. This path is combinational.
  - Bits above ADDR_BITS+1 are truncated, so addresses wrap modulo memory size.
- **State.**
  - req_pc: next sequential byte address.
  - resp_valid, resp_pc: one in-flight request.
  - FIFO: 2 entries, count 0..2, each entry {pc, instr}.
- **Reset values (rst high at a posedge).**
  - req_pc=RESET_PC, resp_valid=0, count=0.
  - out_valid=0; out_pc=0, out_instruction=0.
  - Reset mid-operation discards every buffered and in-flight entry.
- **Per cycle, not redirecting.**
  - enq = resp_valid: at the posedge, push {resp_pc, im_instruction}.
  - deq = out_valid & out_ready.
  - next_count = count + enq - deq.
  - issue = (next_count < 2).
  - If issue: resp_valid<=1, resp_pc<=req_pc, req_pc<=req_pc+4.
  - If not issue: resp_valid<=0 and req_pc holds. The memory still latches the address, but the returned data is ignored.
  - Simultaneous enq and deq with count=2 is legal: next_count=2, so no issue.
- **Redirect cycle (highest priority below rst).**
  - A deq occurring in this cycle completes normally.
  - All other FIFO entries and the in-flight response are dropped; count<=0.
  - The redirect target is issued this same cycle: resp_valid<=1, resp_pc<=aligned target, req_pc<=aligned target+4.
  - redirect_pc[1:0] is ignored.
- **Latency.**
  - rst released at edge T0: im_address=RESET_PC word during cycle T0.
  - Data returns in T0+1 and is enqueued at edge T0+2.
  - out_valid is high in cycle T0+2.
  - Redirect to decode: 2 cycles.
  - Sustained throughput with out_ready held high: 1 instruction/cycle.
- **Output timing.** out_valid = (count!=0). out_pc/out_instruction come from the FIFO head and are registered.
  - Contents are stable while out_valid & !out_ready, except when a redirect or reset flushes the FIFO.
- **PC arithmetic.** 32-bit, wraps from 32'hFFFF_FFFC to 0.

Optional Feature:
FETCH_BYPASS_EN
- **Defined:** when count==0 and resp_valid, the output is combinational: out_valid=1, out_instruction=im_instruction, out_pc=resp_pc.
  - If out_ready is high, the entry is consumed and not enqueued.
  - First-instruction and redirect latency drop to 1 cycle.
- **Undefined:** registered-only output as described above.
- In both cases the issue rule uses the same next_count computation.

Decomposition:
- Shared package/def.v holds DATA_BITS (32), INSTR_BYTES=4, and the PC increment constant.
- Natural sub-module: fetch_skid_fifo. It is a 2-entry {pc, instr} FIFO with push, pop, flush and count outputs, plus synchronous active-high reset.

Test Plan:
- **Reset start:** memory word0=32'h1111_0001, word1=32'h1111_0002, out_ready=1.
  - Required: out_valid rises 2 cycles after rst falls, with pc 0 then 4 on consecutive cycles.
- **Backpressure:** out_ready=0 for 6 cycles mid-stream.
  - Required: count saturates at 2; im_address stalls; no instruction is lost or duplicated.
  - Required: on release, pcs continue contiguously (e.g. 8, C, 10).
- **Redirect with full FIFO:** redirect_pc=32'h0000_0102.
  - Required: buffered entries dropped; next out_pc=32'h100; im_address=64 in the redirect cycle.
- **Redirect plus simultaneous deq:**
  - Required: the accepted instruction is delivered exactly once; nothing else from the old stream appears.
- **Wrap:** ADDR_BITS=10, redirect to 32'h0000_0FFC.
  - Required: im_address 1023 then 0; out_pc 32'hFFC then 32'h1000.
- **Reset mid-stream with out_valid=1:**
  - Required: out_valid=0 the next cycle; fetch restarts at RESET_PC.
  - With FETCH_BYPASS_EN: first out_valid appears 1 cycle after rst falls.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: data width, instruction
// size, PC increment and the buffered {pc, instr} entry type.
package instruction_fetch_pkg;

    localparam int unsigned DATA_BITS   = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // Sequential fetch step in bytes.
    localparam logic [DATA_BITS-1:0] PC_INC = DATA_BITS'(INSTR_BYTES);

    typedef struct packed {
        logic [DATA_BITS-1:0] pc;
        logic [DATA_BITS-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto an instruction boundary.
    function automatic logic [DATA_BITS-1:0] align_pc(input logic [DATA_BITS-1:0] pc);
        return {pc[DATA_BITS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_skid_fifo.sv
// Two-entry {pc, instr} buffer between the memory response and decode.
// The head entry lives in its own register so the consumer sees registered data.
module instruction_fetch_skid_fifo
    import instruction_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    // Next-state: flush wins, otherwise shift on pop and fill the first free slot on push.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_i) begin
                        head_d  = push_data_i;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        head_d = push_data_i;
                    end else if (push_i) begin
                        tail_d  = push_data_i;
                        count_d = 2'd2;
                    end else if (pop_i) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    // Push without pop cannot occur when full: the issue rule stops it.
                    if (pop_i) begin
                        head_d = tail_q;
                        if (push_i) begin
                            tail_d = push_data_i;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    // State registers with synchronous reset clearing data and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: drives the synchronous-read instruction memory,
// buffers returned words and hands {pc, instruction} to decode over valid/ready.
// Execute redirects flush the buffer and restart fetch at the new target.
// Build option FETCH_BYPASS_EN: when the buffer is empty, the returning memory
// word is presented to decode combinationally, saving one cycle of latency.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned          ADDR_BITS = 10,
    parameter logic [DATA_BITS-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_BITS-1:0] im_address,
    input  logic [DATA_BITS-1:0] im_instruction,
    input  logic                 redirect_valid,
    input  logic [DATA_BITS-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_instruction,
    output logic [DATA_BITS-1:0] out_pc
);

    logic [DATA_BITS-1:0] req_pc_q, req_pc_d;
    logic [DATA_BITS-1:0] resp_pc_q, resp_pc_d;
    logic                 resp_valid_q, resp_valid_d;

    logic [DATA_BITS-1:0] target_pc;
    logic [DATA_BITS-1:0] fetch_pc;
    logic [1:0]           count;
    logic [2:0]           next_count;
    fetch_entry_t         head;
    fetch_entry_t         resp_entry;
    logic                 bypass;
    logic                 deq;
    logic                 issue;
    logic                 fifo_push;
    logic                 fifo_pop;

    // Address bits outside the memory window and the byte offset are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_pc[DATA_BITS-1:ADDR_BITS+2], fetch_pc[1:0],
                                redirect_pc[1:0]};

    assign target_pc  = align_pc(redirect_pc);
    assign fetch_pc   = redirect_valid ? target_pc : req_pc_q;
    assign im_address = fetch_pc[ADDR_BITS+1:2];

    assign resp_entry = '{pc: resp_pc_q, instr: im_instruction};

`ifdef FETCH_BYPASS_EN
    assign bypass = (count == 2'd0) && resp_valid_q;
`else
    assign bypass = 1'b0;
`endif

    // Decode-facing outputs: buffer head, or the live memory word when bypassing.
    always_comb begin
        out_valid       = (count != 2'd0) || bypass;
        out_pc          = bypass ? resp_pc_q : head.pc;
        out_instruction = bypass ? im_instruction : head.instr;
    end

    assign deq        = out_valid && out_ready;
    assign next_count = {1'b0, count} + {2'b00, resp_valid_q} - {2'b00, deq};
    assign issue      = (next_count < 3'd2);

    // A bypassed word taken by decode is never written into the buffer.
    assign fifo_push = resp_valid_q && !(bypass && out_ready);
    assign fifo_pop  = deq && !bypass;

    instruction_fetch_skid_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (resp_entry),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .count_o     (count)
    );

    // Request sequencing: redirect restarts at the target, otherwise issue only with room.
    always_comb begin
        req_pc_d     = req_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = 1'b0;
        if (redirect_valid) begin
            resp_valid_d = 1'b1;
            resp_pc_d    = target_pc;
            req_pc_d     = target_pc + PC_INC;
        end else if (issue) begin
            resp_valid_d = 1'b1;
            resp_pc_d    = req_pc_q;
            req_pc_d     = req_pc_q + PC_INC;
        end
    end

    // Request state registers; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q     <= RESET_PC;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            req_pc_q     <= req_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
        end
    end

endmodule
